alu_arbiter: RTL and testbench

Shares the single 32-bit integer ALU between two requesters: port 0 is the execute stage and port 1 is the address/branch unit. It accepts one operation at a time through valid/ready handshakes and arbitrates round-robin. It registers the operands, runs them through an internally instantiated ALU, and returns a registered result and Zero flag on one shared response channel tagged with the requester ID. It sits between the pipeline front-end and the ALU datapath and is the only block that drives the ALU's inputs.

---
 rtl/alu_arbiter_if.sv | 40 ++++
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two ALU requesters, the shared response
// consumer and the alu_arbiter. The arbiter connects through the slave
// modport. The requesters and the consumer use the master modport.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [3:0]  req0_ctrl;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [3:0]  req1_ctrl;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a single 32-bit integer ALU.
// Port 0 is the execute stage and port 1 is the address/branch unit.
// Only one operation is in flight at a time, and each operation passes
// through IDLE -> EXEC -> RESP.

// Combinational 32-bit integer ALU.
module alu_core (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  ctrl,
    output logic [31:0] result
);
    // Decode the control code. Any undefined code yields zero.
    always_comb begin
        result = 32'd0;
        case (ctrl)
            4'b0000: result = a + b;
            4'b0001: result = a - b;
            4'b0010: result = a & b;
            4'b0011: result = a | b;
            4'b0100: result = ~(a | b);
            4'b1000: result = {31'd0, (a < b)};
            default: result = 32'd0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    alu_arbiter_if.slave   bus,
    output logic           busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic        prio_reg;
    logic        prio_next;

    logic [31:0] op_a_reg;
    logic [31:0] op_b_reg;
    logic [3:0]  op_ctrl_reg;
    logic        op_id_reg;

    logic [31:0] rsp_result_reg;
    logic        rsp_zero_reg;
    logic        rsp_id_reg;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic        grant_any;
    logic        grant_id;
    logic [31:0] alu_out;

    assign req_valid = {bus.req1_valid, bus.req0_valid};

    // Grant only in IDLE and outside reset. On contention the priority
    // holder wins. Otherwise the single active requester wins.
    always_comb begin
        grant_any = (state_reg == IDLE) && !reset && (|req_valid);
        grant_id  = (&req_valid) ? prio_reg : req_valid[1];
    end

    // Per-port ready is the grant decoded against the port index.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = grant_any && (grant_id == 1'(gi));
        end
    endgenerate

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];

    // Next-state logic and the round-robin pointer. The pointer moves
    // only when a grant resolves real contention. A lone requester
    // leaves the pointer unchanged.
    always_comb begin
        state_next = state_reg;
        prio_next  = prio_reg;
        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    state_next = EXEC;
                    if (&req_valid) begin
                        prio_next = ~grant_id;
                    end
                end
            end
            EXEC:    state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, pointer and operand capture. The operands are latched on the
    // request handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            prio_reg    <= RR_INIT;
            op_a_reg    <= 32'd0;
            op_b_reg    <= 32'd0;
            op_ctrl_reg <= 4'd0;
            op_id_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            prio_reg  <= prio_next;
            if (grant_any) begin
                op_a_reg    <= grant_id ? bus.req1_a    : bus.req0_a;
                op_b_reg    <= grant_id ? bus.req1_b    : bus.req0_b;
                op_ctrl_reg <= grant_id ? bus.req1_ctrl : bus.req0_ctrl;
                op_id_reg   <= grant_id;
            end
        end
    end

    // The ALU sees only the operand registers, so no output depends
    // combinationally on the request operands.
    alu_core u_alu (
        .a      (op_a_reg),
        .b      (op_b_reg),
        .ctrl   (op_ctrl_reg),
        .result (alu_out)
    );

    // Capture the ALU result at the end of EXEC. The captured value holds
    // through RESP until the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_result_reg <= 32'd0;
            rsp_zero_reg   <= 1'b0;
            rsp_id_reg     <= 1'b0;
        end else if (state_reg == EXEC) begin
            rsp_result_reg <= alu_out;
            rsp_zero_reg   <= (alu_out == 32'd0);
            rsp_id_reg     <= op_id_reg;
        end
    end

    assign bus.rsp_valid  = (state_reg == RESP);
    assign bus.rsp_id     = rsp_id_reg;
    assign bus.rsp_result = rsp_result_reg;
    assign bus.rsp_zero   = rsp_zero_reg;
    assign busy           = (state_reg != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with RR_INIT = 0.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    int   n_checks = 0;
    int   n_fails = 0;

    alu_arbiter_if bus();

    alu_arbiter #(.RR_INIT(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Bound the total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int port, input logic valid, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] ctrl);
        if (port == 0) begin
            bus.req0_valid = valid; bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = ctrl;
        end else begin
            bus.req1_valid = valid; bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = ctrl;
        end
    endtask

    task automatic check_rsp(input string tag, input logic exp_id, input logic [31:0] exp_res,
                             input logic exp_zero);
        check_eq({tag, ".rsp_valid"}, bus.rsp_valid, 1);
        check_eq({tag, ".rsp_id"}, bus.rsp_id, exp_id);
        check_eq({tag, ".rsp_result"}, bus.rsp_result, exp_res);
        check_eq({tag, ".rsp_zero"}, bus.rsp_zero, exp_zero);
        $display("rsp %s: id=%0d result=0x%08h zero=%0d", tag, bus.rsp_id, bus.rsp_result, bus.rsp_zero);
    endtask

    // One uncontended operation with rsp_ready held high. The response
    // must appear exactly two cycles after the ready cycle.
    task automatic run_single(input string tag, input int port, input logic [31:0] a,
                              input logic [31:0] b, input logic [3:0] ctrl,
                              input logic [31:0] exp_res, input logic exp_zero);
        drive_req(port, 1'b1, a, b, ctrl);
        #1;
        check_eq({tag, ".ready"}, (port == 0) ? bus.req0_ready : bus.req1_ready, 1);
        cycle();
        drive_req(port, 1'b0, 32'd0, 32'd0, 4'd0);
        check_eq({tag, ".busy_exec"}, busy, 1);
        check_eq({tag, ".no_early_rsp"}, bus.rsp_valid, 0);
        cycle();
        check_rsp(tag, (port == 1), exp_res, exp_zero);
        cycle();
        check_eq({tag, ".busy_after"}, busy, 0);
    endtask

    initial begin
        drive_req(0, 1'b1, 32'd1, 32'd1, 4'd0);
        drive_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        bus.rsp_ready = 1'b1;
        reset = 1'b1;

        // Check the reset state while a request is already pending.
        cycle();
        cycle();
        check_eq("reset.req0_ready", bus.req0_ready, 0);
        check_eq("reset.req1_ready", bus.req1_ready, 0);
        check_eq("reset.rsp_valid", bus.rsp_valid, 0);
        check_eq("reset.rsp_id", bus.rsp_id, 0);
        check_eq("reset.rsp_result", bus.rsp_result, 0);
        check_eq("reset.rsp_zero", bus.rsp_zero, 0);
        check_eq("reset.busy", busy, 0);
        drive_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        reset = 1'b0;
        cycle();

        // Basic add on requester 0.
        run_single("add5_7", 0, 32'd5, 32'd7, 4'b0000, 32'd12, 1'b0);

        // Both requesters contend continuously. Grants must alternate.
        drive_req(0, 1'b1, 32'd9, 32'd9, 4'b0001);
        drive_req(1, 1'b1, 32'd3, 32'd4, 4'b1000);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("rr%0d.req0_ready", i), bus.req0_ready, (i % 2 == 0));
            check_eq($sformatf("rr%0d.req1_ready", i), bus.req1_ready, (i % 2 == 1));
            cycle();
            cycle();
            check_eq($sformatf("rr%0d.resp_ready0", i), bus.req0_ready, 0);
            check_eq($sformatf("rr%0d.resp_ready1", i), bus.req1_ready, 0);
            if (i % 2 == 0) check_rsp($sformatf("rr%0d", i), 1'b0, 32'd0, 1'b1);
            else            check_rsp($sformatf("rr%0d", i), 1'b1, 32'd1, 1'b0);
            cycle();
        end
        drive_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive_req(1, 1'b0, 32'd0, 32'd0, 4'd0);

        // Hold RESP under backpressure while another request waits.
        bus.rsp_ready = 1'b0;
        drive_req(0, 1'b1, 32'd1, 32'd2, 4'b0000);
        #1;
        check_eq("bp.req0_ready", bus.req0_ready, 1);
        cycle();
        drive_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive_req(1, 1'b1, 32'd6, 32'd6, 4'b0000);
        cycle();
        for (int i = 0; i < 5; i++) begin
            check_rsp($sformatf("bp%0d", i), 1'b0, 32'd3, 1'b0);
            check_eq($sformatf("bp%0d.req0_ready", i), bus.req0_ready, 0);
            check_eq($sformatf("bp%0d.req1_ready", i), bus.req1_ready, 0);
            check_eq($sformatf("bp%0d.busy", i), busy, 1);
            cycle();
        end
        drive_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        bus.rsp_ready = 1'b1;
        check_eq("bp.last_rsp_valid", bus.rsp_valid, 1);
        cycle();
        check_eq("bp.release_busy", busy, 0);
        check_eq("bp.release_rsp_valid", bus.rsp_valid, 0);

        // Exercise each ALU code on requester 1.
        run_single("and", 1, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0010, 32'h00F000F0, 1'b0);
        run_single("or",  1, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0011, 32'hFFF0FFF0, 1'b0);
        run_single("nor", 1, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0100, 32'h000F000F, 1'b0);
        run_single("add_wrap", 1, 32'hFFFFFFFF, 32'd1, 4'b0000, 32'd0, 1'b1);
        run_single("sub_neg", 1, 32'd5, 32'd7, 4'b0001, 32'hFFFFFFFE, 1'b0);
        run_single("slt_false", 1, 32'd4, 32'd3, 4'b1000, 32'd0, 1'b1);
        run_single("slt_unsigned", 1, 32'd1, 32'h80000000, 4'b1000, 32'd1, 1'b0);
        run_single("ctrl0111", 1, 32'd5, 32'd7, 4'b0111, 32'd0, 1'b1);

        // Contention moves the pointer to requester 1. Resetting during
        // EXEC must drop the operation and restore the initial priority.
        drive_req(0, 1'b1, 32'd9, 32'd9, 4'b0001);
        drive_req(1, 1'b1, 32'd3, 32'd4, 4'b1000);
        #1;
        check_eq("rst_exec.pre_grant0", bus.req0_ready, 1);
        cycle();
        drive_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        check_eq("rst_exec.in_exec", busy, 1);
        reset = 1'b1;
        cycle();
        check_eq("rst_exec.rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_exec.busy", busy, 0);
        check_eq("rst_exec.rsp_result", bus.rsp_result, 0);
        reset = 1'b0;
        cycle();
        check_eq("rst_exec.no_rsp", bus.rsp_valid, 0);
        drive_req(0, 1'b1, 32'hFF00FF00, 32'h0F0F0F0F, 4'b0010);
        drive_req(1, 1'b1, 32'd3, 32'd4, 4'b1000);
        #1;
        check_eq("rst_exec.prio_req0", bus.req0_ready, 1);
        check_eq("rst_exec.prio_req1", bus.req1_ready, 0);
        cycle();
        drive_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        cycle();
        check_rsp("rst_exec.after", 1'b0, 32'h0F000F00, 1'b0);
        cycle();

        // A lone requester 1 is granted back to back without stalling.
        drive_req(1, 1'b1, 32'd10, 32'd20, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("solo1_%0d.ready", i), bus.req1_ready, 1);
            cycle();
            cycle();
            check_rsp($sformatf("solo1_%0d", i), 1'b1, 32'd30, 1'b0);
            cycle();
        end
        drive_req(1, 1'b0, 32'd0, 32'd0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
